// File: rtl/nms_window_core.sv
// rtl/nms_window_core.sv - Canny non-maximum suppression with double-threshold classification
module nms_window_core #(
    parameter int IMG_WIDTH  = 508,
    parameter int IMG_HEIGHT = 634,
    parameter int GRAD_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [GRAD_W+1:0] in_p11,
    input  logic [GRAD_W+1:0] in_p12,
    input  logic [GRAD_W+1:0] in_p13,
    input  logic [GRAD_W+1:0] in_p21,
    input  logic [GRAD_W+1:0] in_p22,
    input  logic [GRAD_W+1:0] in_p23,
    input  logic [GRAD_W+1:0] in_p31,
    input  logic [GRAD_W+1:0] in_p32,
    input  logic [GRAD_W+1:0] in_p33,
    input  logic [GRAD_W-1:0] th_low,
    input  logic [GRAD_W-1:0] th_high,
    output logic              out_valid,
    output logic [GRAD_W-1:0] out_mag,
    output logic [1:0]        out_dir,
    output logic [1:0]        out_class,
    output logic              out_eof
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [GRAD_W-1:0] th_low_q;
    logic [GRAD_W-1:0] th_high_q;

    logic [CW-1:0]     cur_col;
    logic [RW-1:0]     cur_row;
    logic              sof_hit;
    logic              last_col;
    logic              last_row;
    logic              border;
    logic              frame_end;
    logic [1:0]        dir;
    logic [GRAD_W-1:0] na;
    logic [GRAD_W-1:0] nb;

    logic              s1_valid;
    logic [GRAD_W-1:0] s1_mag;
    logic [GRAD_W-1:0] s1_na;
    logic [GRAD_W-1:0] s1_nb;
    logic [1:0]        s1_dir;
    logic              s1_border;
    logic              s1_eof;

    logic              keep;
    logic [GRAD_W-1:0] kept_mag;
    logic [1:0]        cls;

    // Neighbour direction bits carry no information for suppression.
    logic unused_dir_bits;
    assign unused_dir_bits = ^{in_p11[GRAD_W+1:GRAD_W], in_p12[GRAD_W+1:GRAD_W],
                               in_p13[GRAD_W+1:GRAD_W], in_p21[GRAD_W+1:GRAD_W],
                               in_p23[GRAD_W+1:GRAD_W], in_p31[GRAD_W+1:GRAD_W],
                               in_p32[GRAD_W+1:GRAD_W], in_p33[GRAD_W+1:GRAD_W]};

    always_comb begin
        sof_hit   = in_valid && in_sof;
        cur_col   = in_sof ? '0 : col;
        cur_row   = in_sof ? '0 : row;
        last_col  = (cur_col == COL_LAST);
        last_row  = (cur_row == ROW_LAST);
        border    = (cur_row == '0) || last_row || (cur_col == '0) || last_col;
        frame_end = last_row && last_col;
        dir       = in_p22[GRAD_W+1:GRAD_W];
        na        = in_p21[GRAD_W-1:0];
        nb        = in_p23[GRAD_W-1:0];
        case (dir)
            2'd1: begin na = in_p13[GRAD_W-1:0]; nb = in_p31[GRAD_W-1:0]; end
            2'd2: begin na = in_p12[GRAD_W-1:0]; nb = in_p32[GRAD_W-1:0]; end
            2'd3: begin na = in_p11[GRAD_W-1:0]; nb = in_p33[GRAD_W-1:0]; end
            default: ;
        endcase
    end

    // Position tracking; IDLE counters already sit at the origin, so the
    // first frame lines up even if the source never raises in_sof.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            th_low_q  <= '0;
            th_high_q <= '1;
        end else begin
            if (state == ST_IDLE && (sof_hit || (in_valid && frame_end)))
                state <= ST_RUN;
            if (in_valid) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
            if (sof_hit) begin
                th_low_q  <= (th_low < th_high) ? th_low  : th_high;
                th_high_q <= (th_low < th_high) ? th_high : th_low;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mag    <= '0;
            s1_na     <= '0;
            s1_nb     <= '0;
            s1_dir    <= '0;
            s1_border <= 1'b0;
            s1_eof    <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mag    <= in_p22[GRAD_W-1:0];
                s1_na     <= na;
                s1_nb     <= nb;
                s1_dir    <= dir;
                s1_border <= border;
                s1_eof    <= frame_end;
            end
        end
    end

    always_comb begin
        keep     = !s1_border && (s1_mag >= s1_na) && (s1_mag >= s1_nb) && (s1_mag != '0);
        kept_mag = keep ? s1_mag : '0;
        if (kept_mag >= th_high_q)
            cls = 2'd2;
        else if (kept_mag >= th_low_q && kept_mag != '0)
            cls = 2'd1;
        else
            cls = 2'd0;
    end

    // Data outputs hold through gaps so downstream may sample them lazily.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_dir   <= '0;
            out_class <= '0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            out_eof   <= s1_valid && s1_eof;
            if (s1_valid) begin
                out_mag   <= kept_mag;
                out_dir   <= s1_dir;
                out_class <= cls;
            end
        end
    end

endmodule

// File: tb/tb_nms_window_core.sv
// tb/tb_nms_window_core.sv - randomized and directed self-checking bench for nms_window_core
module tb_nms_window_core;
    localparam int W  = 40;
    localparam int H  = 14;
    localparam int GW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [GW+1:0] pix [9];
    logic [GW-1:0] th_low = '0;
    logic [GW-1:0] th_high = '0;
    logic          out_valid;
    logic [GW-1:0] out_mag;
    logic [1:0]    out_dir;
    logic [1:0]    out_class;
    logic          out_eof;

    typedef struct packed {
        logic          v;
        logic [GW-1:0] mag;
        logic [1:0]    dir;
        logic [1:0]    cls;
        logic          eof;
    } exp_t;

    exp_t          d1, exp_now, last;
    int            m_idx;
    logic [GW-1:0] tl_q, th_q;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    nms_window_core #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .GRAD_W(GW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_p11(pix[0]), .in_p12(pix[1]), .in_p13(pix[2]),
        .in_p21(pix[3]), .in_p22(pix[4]), .in_p23(pix[5]),
        .in_p31(pix[6]), .in_p32(pix[7]), .in_p33(pix[8]),
        .th_low(th_low), .th_high(th_high),
        .out_valid(out_valid), .out_mag(out_mag), .out_dir(out_dir),
        .out_class(out_class), .out_eof(out_eof)
    );

    // One clock of stimulus; the model result for this window becomes the
    // expectation one sample later (two stages after the input cycle).
    task automatic cycle(input bit v, input bit s);
        exp_t m;
        int row, col;
        logic [GW-1:0] c, a, b;
        in_valid = v;
        in_sof = s;
        m = last;
        m.v = 1'b0;
        m.eof = 1'b0;
        if (v) begin
            if (s) begin
                tl_q = (th_low < th_high) ? th_low : th_high;
                th_q = (th_low < th_high) ? th_high : th_low;
                m_idx = 0;
            end
            row = m_idx / W;
            col = m_idx % W;
            c = pix[4][GW-1:0];
            case (pix[4][GW+1:GW])
                2'd0: begin a = pix[3][GW-1:0]; b = pix[5][GW-1:0]; end
                2'd1: begin a = pix[2][GW-1:0]; b = pix[6][GW-1:0]; end
                2'd2: begin a = pix[1][GW-1:0]; b = pix[7][GW-1:0]; end
                default: begin a = pix[0][GW-1:0]; b = pix[8][GW-1:0]; end
            endcase
            m.v = 1'b1;
            m.dir = pix[4][GW+1:GW];
            m.mag = (c >= a && c >= b && c != 0 && row != 0 && row != H-1
                     && col != 0 && col != W-1) ? c : '0;
            m.cls = (m.mag >= th_q) ? 2'd2 : (m.mag >= tl_q && m.mag != 0) ? 2'd1 : 2'd0;
            m.eof = (m_idx == W*H-1);
            m_idx = (m_idx + 1) % (W*H);
            last = m;
        end
        @(posedge clk);
        #1;
        exp_now = d1;
        d1 = m;
    endtask

    task automatic set_win(input logic [1:0] d, input logic [GW-1:0] c,
                           input logic [GW-1:0] na, input logic [GW-1:0] nb);
        for (int k = 0; k < 9; k++) pix[k] = '0;
        pix[4] = {d, c};
        case (d)
            2'd0: begin pix[3][GW-1:0] = na; pix[5][GW-1:0] = nb; end
            2'd1: begin pix[2][GW-1:0] = na; pix[6][GW-1:0] = nb; end
            2'd2: begin pix[1][GW-1:0] = na; pix[7][GW-1:0] = nb; end
            default: begin pix[0][GW-1:0] = na; pix[8][GW-1:0] = nb; end
        endcase
    endtask

    task automatic advance_to(input int idx);
        while (m_idx != idx) begin
            set_win(2'd0, '0, '0, '0);
            cycle(1'b1, 1'b0);
        end
    endtask

    task automatic reset_dut();
        in_valid = 1'b0;
        in_sof = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_idx = 0;
        tl_q = '0;
        th_q = '1;
        d1 = '0;
        last = '0;
        exp_now = '0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 9; k++) pix[k] = '0;
        reset_dut();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        if (out_mag !== '0) begin errors++; $display("FAIL reset_mag got %0d want 0", out_mag); end
        if (out_dir !== 2'd0) begin errors++; $display("FAIL reset_dir got %0d want 0", out_dir); end
        if (out_class !== 2'd0) begin errors++; $display("FAIL reset_class got %0d want 0", out_class); end
        if (out_eof !== 1'b0) begin errors++; $display("FAIL reset_eof got %0b want 0", out_eof); end
    endtask

    task automatic test_directed();
        th_low = 24'd50;
        th_high = 24'd120;
        set_win(2'd0, '0, '0, '0);
        cycle(1'b1, 1'b1);
        advance_to(5*W + 5);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        set_win(2'd0, 24'd100, 24'd90, 24'd100);
        cycle(1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %0b want 0", out_valid); end
        cycle(1'b0, 1'b0);
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_two got %0b want 1", out_valid); end
        if (out_mag !== 24'd100) begin errors++; $display("FAIL dir0_mag got %0d want 100", out_mag); end
        if (out_class !== 2'd1) begin errors++; $display("FAIL dir0_class got %0d want 1", out_class); end
        if (out_dir !== 2'd0) begin errors++; $display("FAIL dir0_dir got %0d want 0", out_dir); end
        cycle(1'b0, 1'b0);
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid got %0b want 0", out_valid); end
        if (out_mag !== 24'd100) begin errors++; $display("FAIL gap_hold_mag got %0d want 100", out_mag); end
        if (out_eof !== 1'b0) begin errors++; $display("FAIL gap_eof got %0b want 0", out_eof); end
        set_win(2'd2, 24'd100, 24'd101, 24'd0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        checks += 3;
        if (out_mag !== 24'd0) begin errors++; $display("FAIL dir2_mag got %0d want 0", out_mag); end
        if (out_class !== 2'd0) begin errors++; $display("FAIL dir2_class got %0d want 0", out_class); end
        if (out_dir !== 2'd2) begin errors++; $display("FAIL dir2_dir got %0d want 2", out_dir); end
        set_win(2'd1, 24'd200, 24'd0, 24'd0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        checks += 2;
        if (out_mag !== 24'd200) begin errors++; $display("FAIL dir1_mag got %0d want 200", out_mag); end
        if (out_class !== 2'd2) begin errors++; $display("FAIL dir1_class got %0d want 2", out_class); end
    endtask

    task automatic test_threshold_swap();
        logic [GW-1:0] cen [3];
        logic [1:0]    want [3];
        cen = '{24'd150, 24'd250, 24'd99};
        want = '{2'd1, 2'd2, 2'd0};
        th_low = 24'd200;
        th_high = 24'd100;
        set_win(2'd0, '0, '0, '0);
        cycle(1'b1, 1'b1);
        advance_to(2*W + 3);
        for (int i = 0; i < 3; i++) begin
            set_win(2'd3, cen[i], '0, '0);
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
            checks += 2;
            if (out_mag !== cen[i]) begin errors++; $display("FAIL swap_mag[%0d] got %0d want %0d", i, out_mag, cen[i]); end
            if (out_class !== want[i]) begin errors++; $display("FAIL swap_class[%0d] got %0d want %0d", i, out_class, want[i]); end
        end
    endtask

    task automatic test_full_frame();
        int n_out, n_strong, n_nz, n_eof, eof_at, n_bad_border;
        n_out = 0; n_strong = 0; n_nz = 0; n_eof = 0; eof_at = -1; n_bad_border = 0;
        th_low = 24'd10;
        th_high = 24'd20;
        for (int i = 0; i < W*H + 2; i++) begin
            if (i < W*H) begin
                set_win(2'($urandom_range(0, 3)), 24'd300, '0, '0);
                cycle(1'b1, i == 0);
            end else begin
                cycle(1'b0, 1'b0);
            end
            if (out_valid) begin
                if (out_class == 2'd2) n_strong++;
                if (out_mag != 0) n_nz++;
                if (out_eof) begin n_eof++; eof_at = n_out; end
                if ((n_out / W == 0 || n_out / W == H-1 || n_out % W == 0 || n_out % W == W-1)
                    && (out_mag != 0 || out_class != 0)) n_bad_border++;
                n_out++;
            end
        end
        checks += 6;
        if (n_out !== W*H) begin errors++; $display("FAIL frame_count got %0d want %0d", n_out, W*H); end
        if (n_strong !== (W-2)*(H-2)) begin errors++; $display("FAIL frame_strong got %0d want %0d", n_strong, (W-2)*(H-2)); end
        if (n_nz !== (W-2)*(H-2)) begin errors++; $display("FAIL frame_nonzero got %0d want %0d", n_nz, (W-2)*(H-2)); end
        if (n_bad_border !== 0) begin errors++; $display("FAIL frame_border got %0d want 0", n_bad_border); end
        if (n_eof !== 1) begin errors++; $display("FAIL frame_eof_count got %0d want 1", n_eof); end
        if (eof_at !== W*H-1) begin errors++; $display("FAIL frame_eof_pos got %0d want %0d", eof_at, W*H-1); end
    endtask

    task automatic test_reset_inflight();
        int n_valid;
        th_low = 24'd5;
        th_high = 24'd9;
        set_win(2'd0, 24'd50, '0, '0);
        cycle(1'b1, 1'b1);
        set_win(2'd0, 24'd60, '0, '0);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0b want 0", out_valid); end
        if (out_mag !== '0) begin errors++; $display("FAIL midrst_mag got %0d want 0", out_mag); end
        if (out_dir !== 2'd0) begin errors++; $display("FAIL midrst_dir got %0d want 0", out_dir); end
        if (out_class !== 2'd0) begin errors++; $display("FAIL midrst_class got %0d want 0", out_class); end
        if (out_eof !== 1'b0) begin errors++; $display("FAIL midrst_eof got %0b want 0", out_eof); end
        reset_dut();
        n_valid = 0;
        repeat (4) begin
            cycle(1'b0, 1'b0);
            if (out_valid) n_valid++;
        end
        checks++;
        if (n_valid !== 0) begin errors++; $display("FAIL midrst_drop got %0d valids want 0", n_valid); end
    endtask

    task automatic test_random_gaps();
        int n_in, n_out, n_eof, resync_done, post;
        bit v, s;
        n_in = 0; n_out = 0; n_eof = 0; resync_done = 0; post = 0;
        th_low = 24'($urandom_range(0, 40));
        th_high = 24'($urandom_range(0, 40));
        for (int i = 0; i < 2000 && post < 150; i++) begin
            for (int k = 0; k < 9; k++) pix[k] = {2'($urandom_range(0, 3)), 24'($urandom_range(0, 31))};
            v = (n_in == 0) || ($urandom_range(0, 9) < 3);
            s = 1'b0;
            if (v && n_in == 0) s = 1'b1;
            if (v && !resync_done && m_idx == 10*W + 37) begin
                s = 1'b1;
                resync_done = 1;
                th_low = 24'($urandom_range(0, 40));
                th_high = 24'($urandom_range(0, 40));
            end
            if (resync_done) post++;
            if (v) n_in++;
            cycle(v, s);
            if (out_valid) n_out++;
            if (out_eof) n_eof++;
            if (exp_now.v) begin
                checks += 5;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want 1", i, out_valid); end
                if (out_mag !== exp_now.mag) begin errors++; $display("FAIL rnd_mag cyc %0d got %0d want %0d", i, out_mag, exp_now.mag); end
                if (out_dir !== exp_now.dir) begin errors++; $display("FAIL rnd_dir cyc %0d got %0d want %0d", i, out_dir, exp_now.dir); end
                if (out_class !== exp_now.cls) begin errors++; $display("FAIL rnd_class cyc %0d got %0d want %0d", i, out_class, exp_now.cls); end
                if (out_eof !== exp_now.eof) begin errors++; $display("FAIL rnd_eof cyc %0d got %0b want %0b", i, out_eof, exp_now.eof); end
            end else begin
                checks += 3;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_gap cyc %0d got %0b want 0", i, out_valid); end
                if (out_eof !== 1'b0) begin errors++; $display("FAIL rnd_gap_eof cyc %0d got %0b want 0", i, out_eof); end
                if (out_mag !== exp_now.mag) begin errors++; $display("FAIL rnd_hold cyc %0d got %0d want %0d", i, out_mag, exp_now.mag); end
            end
        end
        for (int j = 0; j < 2; j++) begin
            cycle(1'b0, 1'b0);
            if (out_valid) n_out++;
            if (out_eof) n_eof++;
        end
        checks += 3;
        if (resync_done !== 1) begin errors++; $display("FAIL rnd_resync_reached got %0d want 1", resync_done); end
        if (n_out !== n_in) begin errors++; $display("FAIL rnd_count got %0d outputs want %0d", n_out, n_in); end
        if (n_eof !== 0) begin errors++; $display("FAIL rnd_no_eof got %0d want 0", n_eof); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_threshold_swap();
        test_full_frame();
        test_reset_inflight();
        test_random_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nms_window_core.md
# nms_window_core

Non-maximum suppression and double-threshold classifier for the Canny edge pipeline. It consumes the 3x3 window of packed gradient words produced by the non-max shift-RAM window generator: 26 bits per pixel, direction in [25:24], magnitude in [23:0]. It emits one thinned, classified magnitude per window to the hysteresis stage, and tracks frame position so it can zero border pixels and flag end of frame.

## Interface
- IMG_WIDTH, 508: window positions per row (valid columns delivered by the window generator)
- IMG_HEIGHT, 634: window rows per frame
- GRAD_W, 24: magnitude width; packed word width is GRAD_W+2
- Reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  pipeline clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  window valid strobe, one window per high cycle (driven by matrix_clken)
- in_sof  in  1  qualifies in_valid; marks the window at (row 0, col 0)
- in_p11..in_p33  in  26 each  window pixels, row-major, p22 centre
- th_low  in  GRAD_W  weak threshold, latched at SOF
- th_high  in  GRAD_W  strong threshold, latched at SOF
- out_valid  out  1  result strobe
- out_mag  out  GRAD_W  centre magnitude after suppression (0 = suppressed)
- out_dir  out  2  centre direction, passed through
- out_class  out  2  0 none, 1 weak, 2 strong; 3 never driven
- out_eof  out  1  high with out_valid on the last pixel of the frame

## Operation
- Direction code selects the neighbour pair:
  - 0 (0°): p21 and p23
  - 1 (45°): p13 and p31
  - 2 (90°): p12 and p32
  - 3 (135°): p11 and p33
- Keep rule: the centre is kept iff mag22 >= nA, mag22 >= nB, and mag22 != 0. Otherwise out_mag = 0. All comparisons are unsigned and GRAD_W wide.
- Border rule: if row == 0, row == IMG_HEIGHT-1, col == 0 or col == IMG_WIDTH-1, then out_mag = 0 and out_class = 0, regardless of the keep rule.
- Classification uses the kept out_mag:
  - out_mag >= th_high_q: class 2
  - else out_mag >= th_low_q and out_mag != 0: class 1
  - else: class 0
- Threshold latch: on in_valid && in_sof, th_low_q <= min(th_low, th_high) and th_high_q <= max(th_low, th_high). The latched values are used starting with that same SOF window. Reset values: th_low_q = 0, th_high_q = all-ones.
- Position counters (col, row):
  - in_valid && in_sof forces the current window to (0,0); the next window is (0,1).
  - Otherwise each in_valid advances col. When col == IMG_WIDTH-1, col wraps to 0 and row increments. When row == IMG_HEIGHT-1 and col == IMG_WIDTH-1, both wrap to 0 and that window carries the eof tag.
  - Counters hold when in_valid is low.
- Position states are IDLE (awaiting first SOF after reset) and RUN.
  - In IDLE, windows are processed with the position treated as (0,0) onward, so the first frame works even without in_sof.
  - Any SOF in RUN resynchronises the counters mid-frame. No eof is emitted for the abandoned frame.

## Timing
- Two-stage pipeline. Both stages advance every clock, and a valid bit travels with the data.
  - Stage 1 registers: centre magnitude, selected nA/nB, direction, border flag, eof tag, valid.
  - Stage 2 registers: keep/compare result, classification, all outputs.
- Latency: exactly 2 clk from in_valid to out_valid. Back-to-back windows give back-to-back results. Input gaps appear unchanged on the output.
- All outputs reset to 0: out_valid, out_mag, out_dir, out_class, out_eof. Counters reset to 0 and state to IDLE.
- When out_valid = 0, out_mag, out_dir and out_class hold their last values; out_eof = 0.
- in_sof without in_valid is ignored.
- Asserting rst_n low mid-frame clears the pipeline immediately. Windows still in flight are dropped, and no out_valid is produced for them.

## Test plan
- Interior window, dir 0, p22 = 100, p21 = 90, p23 = 100, thresholds 50/120, at (5,5) -> out_mag 100, class 1, out_valid exactly 2 cycles after in_valid.
- Same window with dir 2 and p12 = 101 -> out_mag 0, class 0. With dir 1, p13 = p31 = 0 and p22 = 200 -> out_mag 200, class 2.
- Full frame of 508x634 windows with interior mag 300, neighbours 0, thresholds 10/20 -> 506x632 pixels of class 2. Every border pixel is 0. Exactly one out_eof, on window (633,507), no earlier.
- SOF with th_low = 200, th_high = 100 -> latched low 100, high 200. A centre of 150 classifies as 1.
- Random in_valid gaps (about 30% duty), then SOF asserted at (10,37) -> output count matches input count, positions restart at (0,0), and no eof is emitted for the aborted frame.
- rst_n pulsed low while two windows are in flight -> no out_valid after reset, all outputs 0, and the next SOF frame processes normally.
